rs_cmd_parser: RTL and testbench
================================

Name: rs_cmd_parser

Overview:
- Byte-level command parser between the UART receive/transmit path and the NOR-flash byte-access engine.
- Assembles 2- or 3-byte RS-232 frames into one flash read or write request.
- Waits for flash completion, then returns exactly one response byte over the UART.
- Guards against stalled frames and a hung flash with timeout counters.

Parameters:
- GAP_TIMEOUT, 5000000: clock cycles allowed between consecutive frame bytes (100 ms at 50 MHz).
- FL_TIMEOUT, 50000: clock cycles allowed from fl_start to fl_done (1 ms).

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz
- RST  in  1  reset; one clock, reset is synchronous and active-low (RST=0 resets on the next CLK_50MHZ rising edge)
- rx_data  in  8  received byte from UART
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  response byte to UART
- tx_start  out  1  one-cycle strobe requesting UART transmit
- tx_done  in  1  one-cycle strobe, UART finished sending
- fl_addr  out  8  flash byte address
- fl_wdata  out  8  flash write data
- fl_rdata  in  8  flash read data, valid in the fl_done cycle
- fl_rw  out  1  1 = read, 0 = write
- fl_start  out  1  one-cycle flash request strobe
- fl_done  in  1  one-cycle flash completion strobe
- busy  out  1  high in any state other than IDLE/GET_ADDR/GET_DATA
- err_overrun  out  1  sticky; set when a byte arrives while busy

Behaviour:
- Reset values: all outputs 0, state IDLE, both timeout counters 0.
- Frame format:
  - 'W'(0x57), addr, data: flash write; response 'K'(0x4B), or 'E'(0x45) on flash timeout.
  - 'R'(0x52), addr: flash read; response is the read byte, or 'E' on flash timeout.
  - Any other first byte: response '?'(0x3F), no flash access.
- States: IDLE, GET_ADDR, GET_DATA, FL_REQ, FL_WAIT, TX_REQ, TX_WAIT.
- IDLE
  - On rx_valid, latch the opcode.
  - 'W' or 'R' -> GET_ADDR.
  - Any other byte -> TX_REQ with tx_data=0x3F.
- GET_ADDR
  - On rx_valid, latch fl_addr.
  - Opcode 'R' -> FL_REQ with fl_rw=1; opcode 'W' -> GET_DATA.
- GET_DATA
  - On rx_valid, latch fl_wdata, set fl_rw=0 -> FL_REQ.
- Gap timer
  - Counts in GET_ADDR/GET_DATA and clears on each rx_valid.
  - On reaching GAP_TIMEOUT-1: discard the frame, return to IDLE, send no response.
- FL_REQ
  - fl_start=1 for exactly one cycle -> FL_WAIT.
  - Latency: last frame byte's rx_valid at cycle N gives fl_start at N+1.
- FL_WAIT
  - On fl_done: capture fl_rdata (read) or 0x4B (write) into tx_data -> TX_REQ.
  - Flash timer reaching FL_TIMEOUT-1 before fl_done: tx_data=0x45 -> TX_REQ.
  - fl_done and timeout in the same cycle: fl_done wins.
- TX_REQ
  - tx_start=1 for one cycle -> TX_WAIT.
  - Latency: fl_done at cycle M gives tx_start at M+1.
- TX_WAIT
  - On tx_done -> IDLE. No timeout; the UART always completes.
- fl_addr, fl_wdata and fl_rw hold stable from FL_REQ until the next frame latches new values.
- tx_data holds until the next response.
- rx_valid in FL_REQ/FL_WAIT/TX_REQ/TX_WAIT: byte dropped, err_overrun set. err_overrun clears only on reset.
- A stray fl_done outside FL_WAIT, or a stray tx_done outside TX_WAIT, is ignored.
- RST=0 mid-operation: immediate return to reset values on the next edge. No strobe is emitted in that cycle.
- Counter widths: $clog2(GAP_TIMEOUT) and $clog2(FL_TIMEOUT) bits, saturating never reached (cleared on state exit).

Decomposition:
- Shared package (rs_proto_pkg):
  - Opcode and response constants: OP_WRITE=0x57, OP_READ=0x52, RSP_OK=0x4B, RSP_ERR=0x45, RSP_BADCMD=0x3F.
  - State enum.
  - Timeout defaults.
- One sub-module, timeout_cnt:
  - Inputs: enable, clear.
  - Parameter: LIMIT.
  - Output: expire pulse.
  - Instantiated twice, for the gap timer and the flash timer.

Test Plan:
- Write: rx 0x57,0x10,0xA5 -> fl_start one cycle after the third rx_valid with fl_addr=0x10, fl_wdata=0xA5, fl_rw=0. Then fl_done -> tx_start next cycle, tx_data=0x4B; tx_done -> busy=0.
- Read: rx 0x52,0x22; fl_done with fl_rdata=0x3C -> fl_rw=1, fl_addr=0x22, tx_data=0x3C, tx_start at fl_done+1.
- Bad opcode: rx 0x41 -> no fl_start, tx_data=0x3F, tx_start the cycle after rx_valid.
- Gap timeout (GAP_TIMEOUT=100): rx 0x57, then 0x10, then silence 100 cycles -> back to IDLE, no tx_start. A following 0x52,0x05 executes normally.
- Flash timeout (FL_TIMEOUT=50): read frame, fl_done never asserted -> tx_data=0x45 exactly 50 cycles after fl_start.
- Overrun and reset: rx byte during FL_WAIT -> err_overrun=1, frame unaffected. Then RST=0 for one cycle during TX_WAIT -> all outputs 0, state IDLE, err_overrun=0.

Source files
------------

// File: rtl/rs_proto_pkg.sv
// rs_proto_pkg: shared definitions for the UART-to-flash command parser.
//   - frame opcodes and response bytes
//   - parser state encoding
//   - default timeout lengths in clk cycles (50 MHz)
package rs_proto_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ    = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK     = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR    = 8'h45;  // 'E'
    localparam logic [7:0] RSP_BADCMD = 8'h3F;  // '?'

    localparam int GAP_TIMEOUT_DEF = 5000000;   // 100 ms between frame bytes
    localparam int FL_TIMEOUT_DEF  = 50000;     // 1 ms for a flash access

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_FL_REQ,
        ST_FL_WAIT,
        ST_TX_REQ,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/timeout_cnt.sv
// timeout_cnt: up-counter that pulses o_expire on its LIMIT-th consecutive
// enabled cycle. The count restarts from 0 whenever i_enable is low or
// i_clear is high, so each new wait window starts fresh.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_enable       : count while high
//   i_clear        : restart the window (also suppresses o_expire)
//   o_expire       : one-cycle pulse when the window runs out
module timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);
    import rs_proto_pkg::*;

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_cnt;
    logic         w_at_limit;

    assign w_at_limit = (r_cnt == W'(LIMIT - 1));
    assign o_expire   = i_enable && !i_clear && w_at_limit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rs_cmd_parser.sv
// rs_cmd_parser: turns 2/3-byte UART frames into one flash byte access and
// answers each accepted frame with exactly one UART byte.
//   'W' addr data -> flash write, reply 'K' (or 'E' on flash timeout)
//   'R' addr      -> flash read, reply read byte (or 'E' on flash timeout)
//   other opcode  -> reply '?', no flash access
// Ports:
//   CLK_50MHZ, RST          : clock, synchronous active-low reset
//   rx_data/rx_valid        : received byte strobe from the UART
//   tx_data/tx_start/tx_done: response byte, transmit strobe, UART finished
//   fl_addr/fl_wdata/fl_rw  : flash request (fl_rw 1 = read)
//   fl_start/fl_done/fl_rdata: flash handshake and read data
//   busy                    : frame accepted, not yet answered
//   err_overrun             : sticky, byte arrived while busy
//
// state       | meaning
// ST_IDLE     | waiting for an opcode byte
// ST_GET_ADDR | waiting for the address byte (gap timer running)
// ST_GET_DATA | waiting for the write-data byte (gap timer running)
// ST_FL_REQ   | one-cycle fl_start
// ST_FL_WAIT  | waiting for fl_done (flash timer running)
// ST_TX_REQ   | one-cycle tx_start
// ST_TX_WAIT  | waiting for tx_done
module rs_cmd_parser
    import rs_proto_pkg::*;
#(
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF,
    parameter int FL_TIMEOUT  = FL_TIMEOUT_DEF
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic [7:0] fl_addr,
    output logic [7:0] fl_wdata,
    input  logic [7:0] fl_rdata,
    output logic       fl_rw,
    output logic       fl_start,
    input  logic       fl_done,
    output logic       busy,
    output logic       err_overrun
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_opcode;
    logic [7:0] r_fl_addr;
    logic [7:0] r_fl_wdata;
    logic       r_fl_rw;
    logic [7:0] r_tx_data;
    logic       r_err_overrun;

    logic       w_fl_start;
    logic       w_tx_start;
    logic       w_busy;
    logic       w_gap_en;
    logic       w_fl_en;
    logic       w_gap_expire;
    logic       w_fl_expire;
    logic       w_is_frame_op;

    assign w_is_frame_op = (rx_data == OP_WRITE) || (rx_data == OP_READ);

    // Flash window opens in FL_REQ so the error reply lands FL_TIMEOUT
    // cycles after fl_start, matching the fl_done -> tx_start latency.
    timeout_cnt #(.LIMIT(GAP_TIMEOUT)) u_gap_tmr (
        .i_clk    (CLK_50MHZ),
        .i_rst_n  (RST),
        .i_enable (w_gap_en),
        .i_clear  (rx_valid),
        .o_expire (w_gap_expire)
    );

    timeout_cnt #(.LIMIT(FL_TIMEOUT)) u_fl_tmr (
        .i_clk    (CLK_50MHZ),
        .i_rst_n  (RST),
        .i_enable (w_fl_en),
        .i_clear  (fl_done),
        .o_expire (w_fl_expire)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_state_nxt = w_is_frame_op ? ST_GET_ADDR : ST_TX_REQ;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    w_state_nxt = (r_opcode == OP_READ) ? ST_FL_REQ : ST_GET_DATA;
                end else if (w_gap_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    w_state_nxt = ST_FL_REQ;
                end else if (w_gap_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FL_REQ:  w_state_nxt = ST_FL_WAIT;
            ST_FL_WAIT: begin
                if (fl_done || w_fl_expire) begin
                    w_state_nxt = ST_TX_REQ;
                end
            end
            ST_TX_REQ:  w_state_nxt = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (tx_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are gated by RST so nothing fires in a cycle being reset.
    always_comb begin
        w_fl_start = 1'b0;
        w_tx_start = 1'b0;
        w_busy     = 1'b1;
        w_gap_en   = 1'b0;
        w_fl_en    = 1'b0;
        case (r_state)
            ST_IDLE:     w_busy = 1'b0;
            ST_GET_ADDR: begin w_busy = 1'b0; w_gap_en = 1'b1; end
            ST_GET_DATA: begin w_busy = 1'b0; w_gap_en = 1'b1; end
            ST_FL_REQ:   begin w_fl_start = RST; w_fl_en = 1'b1; end
            ST_FL_WAIT:  w_fl_en = 1'b1;
            ST_TX_REQ:   w_tx_start = RST;
            default:     w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            r_opcode      <= '0;
            r_fl_addr     <= '0;
            r_fl_wdata    <= '0;
            r_fl_rw       <= 1'b0;
            r_tx_data     <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        r_opcode <= rx_data;
                        if (!w_is_frame_op) begin
                            r_tx_data <= RSP_BADCMD;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (rx_valid) begin
                        r_fl_addr <= rx_data;
                        if (r_opcode == OP_READ) begin
                            r_fl_rw <= 1'b1;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (rx_valid) begin
                        r_fl_wdata <= rx_data;
                        r_fl_rw    <= 1'b0;
                    end
                end
                ST_FL_WAIT: begin
                    if (fl_done) begin
                        r_tx_data <= (r_opcode == OP_READ) ? fl_rdata : RSP_OK;
                    end else if (w_fl_expire) begin
                        r_tx_data <= RSP_ERR;
                    end
                end
                default: ;
            endcase
            if (rx_valid && w_busy) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_start    = w_tx_start;
    assign fl_addr     = r_fl_addr;
    assign fl_wdata    = r_fl_wdata;
    assign fl_rw       = r_fl_rw;
    assign fl_start    = w_fl_start;
    assign busy        = w_busy;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_rs_cmd_parser.sv
module tb_rs_cmd_parser;

    localparam int GAP_TO = 100;
    localparam int FL_TO  = 50;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic [7:0] fl_addr;
    logic [7:0] fl_wdata;
    logic [7:0] fl_rdata = '0;
    logic       fl_rw;
    logic       fl_start;
    logic       fl_done = 1'b0;
    logic       busy;
    logic       err_overrun;

    rs_cmd_parser #(.GAP_TIMEOUT(GAP_TO), .FL_TIMEOUT(FL_TO)) dut (
        .CLK_50MHZ   (clk),
        .RST         (RST),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .fl_addr     (fl_addr),
        .fl_wdata    (fl_wdata),
        .fl_rdata    (fl_rdata),
        .fl_rw       (fl_rw),
        .fl_start    (fl_start),
        .fl_done     (fl_done),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard entries: expected flash request and expected response.
    // Response timing reference: 0 = last rx byte, 1 = fl_done, 2 = fl_start + FL_TO.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rw;
    } fl_exp_t;

    typedef struct {
        logic [7:0] data;
        int         kind;
    } rsp_exp_t;

    fl_exp_t  fl_q[$];
    rsp_exp_t rsp_q[$];

    int last_rx = 0;
    int last_fd = 0;
    int last_fs = 0;

    always @(negedge clk) begin
        fl_exp_t  fe;
        rsp_exp_t re;
        int       ref_cyc;
        if (RST) begin
            if (rx_valid) last_rx = cyc;
            if (fl_done)  last_fd = cyc;
            if (fl_start) begin
                last_fs = cyc;
                if (fl_q.size() == 0) begin
                    chk("fl_start_unexpected", 32'd1, 32'd0);
                end else begin
                    fe = fl_q.pop_front();
                    chk("fl_addr", fl_addr, fe.addr);
                    chk("fl_wdata", fl_wdata, fe.wdata);
                    chk("fl_rw", fl_rw, fe.rw);
                    chk("fl_start_latency", cyc, last_rx + 1);
                    chk("busy_in_fl_req", busy, 1'b1);
                end
            end
            if (tx_start) begin
                if (rsp_q.size() == 0) begin
                    chk("tx_start_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("tx_data", tx_data, re.data);
                    if (re.kind == 0)      ref_cyc = last_rx + 1;
                    else if (re.kind == 1) ref_cyc = last_fd + 1;
                    else                   ref_cyc = last_fs + FL_TO;
                    chk("tx_start_latency", cyc, ref_cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_for(input bit want_tx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_tx ? tx_start : fl_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(want_tx ? "tx_start_timeout" : "fl_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_fl_done(input logic [7:0] rd);
        @(posedge clk); #1;
        fl_done  = 1'b1;
        fl_rdata = rd;
        @(posedge clk); #1;
        fl_done  = 1'b0;
    endtask

    task automatic finish_tx(input logic [7:0] exp_rsp);
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        chk("busy_after_tx_done", busy, 1'b0);
        chk("tx_data_hold", tx_data, exp_rsp);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         nbytes;
        int         gap;      // extra idle cycles before the last byte
        bit         fl;
        logic [7:0] rdata;
        int         fd_delay;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic       exp_rw;
        logic [7:0] exp_rsp;
    } vec_t;

    task automatic run_frame(input vec_t v);
        bit ok;
        fl_exp_t  fe;
        rsp_exp_t re;
        if (v.fl) begin
            fe.addr = v.exp_addr; fe.wdata = v.exp_wdata; fe.rw = v.exp_rw;
            fl_q.push_back(fe);
        end
        re.data = v.exp_rsp;
        re.kind = v.fl ? 1 : 0;
        rsp_q.push_back(re);

        if (v.nbytes == 1) begin
            send_byte(v.b0);
        end else begin
            send_byte(v.b0);
            if (v.nbytes == 2) repeat (v.gap) @(posedge clk);
            send_byte(v.b1);
            if (v.nbytes == 3) begin
                repeat (v.gap) @(posedge clk);
                send_byte(v.b2);
            end
        end
        if (v.fl) begin
            wait_for(1'b0, 20, ok);
            if (ok) begin
                repeat (v.fd_delay) @(posedge clk);
                pulse_fl_done(v.rdata);
            end
        end
        wait_for(1'b1, 20, ok);
        if (ok) finish_tx(v.exp_rsp);
    endtask

    vec_t vecs[8];

    initial begin
        bit       ok;
        fl_exp_t  fe;
        rsp_exp_t re;

        //          b0     b1     b2     n  gap fl rdata  dly addr   wdata  rw  rsp
        vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 0,  1, 8'h00, 2, 8'h10, 8'hA5, 1'b0, 8'h4B};
        vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 0,  1, 8'h3C, 0, 8'h22, 8'hA5, 1'b1, 8'h3C};
        vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h3F};
        vecs[3] = '{8'h57, 8'hFF, 8'h00, 3, 0,  1, 8'h00, 5, 8'hFF, 8'h00, 1'b0, 8'h4B};
        vecs[4] = '{8'h52, 8'h00, 8'h00, 2, 0,  1, 8'hE7, 3, 8'h00, 8'h00, 1'b1, 8'hE7};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h3F};
        vecs[6] = '{8'h57, 8'h33, 8'h44, 3, 98, 1, 8'h00, 1, 8'h33, 8'h44, 1'b0, 8'h4B};
        vecs[7] = '{8'h4B, 8'h00, 8'h00, 1, 0,  0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h3F};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_fl_addr", fl_addr, 8'h00);
        chk("rst_fl_wdata", fl_wdata, 8'h00);
        chk("rst_fl_rw", fl_rw, 1'b0);
        chk("rst_fl_start", fl_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_overrun", err_overrun, 1'b0);
        @(posedge clk); #1;
        RST = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Stray completions while idle must be ignored.
        @(posedge clk); #1;
        fl_done = 1'b1; tx_done = 1'b1;
        @(posedge clk); #1;
        fl_done = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_done_busy", busy, 1'b0);

        // Gap timeout: exactly GAP_TO idle cycles after the address byte,
        // the frame is dropped and the next byte is an opcode again.
        send_byte(8'h57);
        send_byte(8'h10);
        repeat (GAP_TO - 1) @(posedge clk);
        run_frame('{8'h52, 8'h05, 8'h00, 2, 0, 1, 8'h6D, 1, 8'h05, 8'h44, 1'b1, 8'h6D});

        // Flash timeout: no fl_done, 'E' reply FL_TO cycles after fl_start.
        fe.addr = 8'h07; fe.wdata = 8'h44; fe.rw = 1'b1;
        fl_q.push_back(fe);
        re.data = 8'h45; re.kind = 2;
        rsp_q.push_back(re);
        send_byte(8'h52);
        send_byte(8'h07);
        wait_for(1'b0, 20, ok);
        wait_for(1'b1, FL_TO + 10, ok);
        if (ok) finish_tx(8'h45);

        // fl_done in the last cycle of the flash window wins over timeout.
        fe.addr = 8'h08; fe.wdata = 8'h44; fe.rw = 1'b1;
        fl_q.push_back(fe);
        re.data = 8'h99; re.kind = 1;
        rsp_q.push_back(re);
        send_byte(8'h52);
        send_byte(8'h08);
        wait_for(1'b0, 20, ok);
        if (ok) begin
            repeat (FL_TO - 2) @(posedge clk);
            pulse_fl_done(8'h99);
        end
        wait_for(1'b1, FL_TO + 10, ok);
        if (ok) finish_tx(8'h99);

        // Overrun during FL_WAIT, then reset while in TX_WAIT.
        fe.addr = 8'h31; fe.wdata = 8'h5A; fe.rw = 1'b0;
        fl_q.push_back(fe);
        re.data = 8'h4B; re.kind = 1;
        rsp_q.push_back(re);
        send_byte(8'h57);
        send_byte(8'h31);
        send_byte(8'h5A);
        wait_for(1'b0, 20, ok);
        chk("overrun_before", err_overrun, 1'b0);
        send_byte(8'h52);
        @(negedge clk);
        chk("overrun_set", err_overrun, 1'b1);
        pulse_fl_done(8'hEE);
        wait_for(1'b1, 20, ok);
        chk("overrun_frame_addr", fl_addr, 8'h31);
        chk("overrun_frame_wdata", fl_wdata, 8'h5A);
        @(posedge clk); #1;
        RST = 1'b0;
        @(posedge clk); #1;
        RST = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_fl_addr", fl_addr, 8'h00);
        chk("mid_rst_fl_wdata", fl_wdata, 8'h00);
        chk("mid_rst_fl_rw", fl_rw, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err_overrun", err_overrun, 1'b0);

        // Parser is back in IDLE: a fresh frame works without any tx_done.
        run_frame('{8'h41, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h3F});

        repeat (2) @(negedge clk);
        chk("fl_queue_empty", fl_q.size(), 32'd0);
        chk("rsp_queue_empty", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
